jk_flip_flop_neg: RTL and testbench

- Bank of WIDTH independent JK flip-flops, triggered on the falling edge of CLK, with asynchronous active-low reset.
- Used as a basic sequential element: a register or state bit that can set, clear, toggle or hold.
- Default configuration is a single-bit JK flip-flop.
- Positional port order is fixed: Q, J, K, CLK, RESET_N.

---
 rtl/jk_flip_flop_neg.sv | 34 +++
 tb/tb_jk_flip_flop_neg.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/jk_flip_flop_neg.sv
// Bank of WIDTH independent JK flops on the CLK falling edge: J0/K1 sets, J1/K0 clears, J1/K1 toggles.
// Latency: Q updates at the sampling edge itself. No backpressure: J/K are accepted on every falling edge.
module jk_flip_flop_neg #(
  parameter int unsigned           WIDTH       = 1,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  output logic [WIDTH-1:0] Q,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic             CLK,
  input  logic             RESET_N
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;

  // Polarity is deliberately inverted from the textbook JK: K alone sets, J alone clears.
  always_comb begin
    w_q_nxt = (r_q & ~J & ~K)
            | (~J & K)
            | (J & K & ~r_q);
  end

  always_ff @(negedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_q <= RESET_VALUE;
    end else begin
      r_q <= w_q_nxt;
    end
  end

  assign Q = r_q;

endmodule

// File: tb/tb_jk_flip_flop_neg.sv
// Directed bench for jk_flip_flop_neg: two 1-bit instances (reset 0 and 1) plus one 4-bit instance,
// checked against a per-bit truth-table model on every clock edge and against literal expectations.
`timescale 1ns/1ps
module tb_jk_flip_flop_neg;

  logic       clk;
  logic       rst_n;
  logic       clk_run;
  logic       j, k;
  logic [3:0] j4, k4;
  logic       q1, q1b;
  logic [3:0] q4;

  int checks = 0;
  int errors = 0;

  // model state
  logic       m1, m1b;
  logic [3:0] m4;

  jk_flip_flop_neg u_dut (
    .Q(q1), .J(j), .K(k), .CLK(clk), .RESET_N(rst_n)
  );

  jk_flip_flop_neg #(.WIDTH(1), .RESET_VALUE(1'b1)) u_dut_rv1 (
    .Q(q1b), .J(j), .K(k), .CLK(clk), .RESET_N(rst_n)
  );

  jk_flip_flop_neg #(.WIDTH(4), .RESET_VALUE(4'b0110)) u_dut4 (
    .Q(q4), .J(j4), .K(k4), .CLK(clk), .RESET_N(rst_n)
  );

  always #5 if (clk_run) clk = ~clk;

  function automatic logic [3:0] jk_rule(input logic [3:0] q, input logic [3:0] jv,
                                         input logic [3:0] kv, input int w);
    logic [3:0] n;
    n = q;
    for (int i = 0; i < w; i++) begin
      case ({jv[i], kv[i]})
        2'b00:   n[i] = q[i];
        2'b01:   n[i] = 1'b1;
        2'b10:   n[i] = 1'b0;
        default: n[i] = ~q[i];
      endcase
    end
    return n;
  endfunction

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1  = 1'b0;
      m1b = 1'b1;
      m4  = 4'b0110;
    end else if (!clk) begin
      m1  = jk_rule({3'b0, m1},  {3'b0, j}, {3'b0, k}, 1)  != 4'b0;
      m1b = jk_rule({3'b0, m1b}, {3'b0, j}, {3'b0, k}, 1) != 4'b0;
      m4  = jk_rule(m4, j4, k4, 4);
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model comparison after every clock edge, rising edges included.
  always @(clk) begin
    if (clk_run) begin
      #1;
      chk("model_q1",  {3'b0, q1},  {3'b0, m1});
      chk("model_q1b", {3'b0, q1b}, {3'b0, m1b});
      chk("model_q4",  q4, m4);
    end
  end

  task automatic lit(input string name, input logic e1, input logic e1b);
    chk({name, "_q1"},  {3'b0, q1},  {3'b0, e1});
    chk({name, "_q1b"}, {3'b0, q1b}, {3'b0, e1b});
  endtask

  task automatic step(input logic jv, input logic kv);
    @(posedge clk);
    #2 j = jv; k = kv;
    @(negedge clk);
    #2;
  endtask

  task automatic step4(input logic [3:0] jv, input logic [3:0] kv);
    @(posedge clk);
    #2 j4 = jv; k4 = kv;
    @(negedge clk);
    #2;
  endtask

  initial begin
    clk = 1'b1; rst_n = 1'b1; clk_run = 1'b0;
    j = 1'b0; k = 1'b0; j4 = 4'b0; k4 = 4'b0;

    // reset with the clock idle
    #2 rst_n = 1'b0;
    #1;
    lit("rst_idle", 1'b0, 1'b1);
    chk("rst_idle_q4", q4, 4'b0110);

    // reset held across three falling edges with set commands present
    j = 1'b0; k = 1'b1; j4 = 4'b0000; k4 = 4'b1111;
    clk_run = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      #2;
      lit("rst_hold", 1'b0, 1'b1);
      chk("rst_hold_q4", q4, 4'b0110);
    end

    @(posedge clk);
    #2 rst_n = 1'b1; j4 = 4'b0; k4 = 4'b0;
    @(negedge clk);
    #2;
    lit("set", 1'b1, 1'b1);
    chk("hold_q4", q4, 4'b0110);

    step(1'b1, 1'b0); lit("clear", 1'b0, 1'b0);

    step(1'b1, 1'b1); lit("tog1", 1'b1, 1'b1);
    step(1'b1, 1'b1); lit("tog2", 1'b0, 1'b0);
    step(1'b1, 1'b1); lit("tog3", 1'b1, 1'b1);
    step(1'b1, 1'b1); lit("tog4", 1'b0, 1'b0);
    step(1'b0, 1'b0); lit("hold1", 1'b0, 1'b0);
    step(1'b0, 1'b0); lit("hold2", 1'b0, 1'b0);

    // J/K changes between falling edges; only the value at the edge counts
    j = 1'b1; k = 1'b0;
    #1 lit("midlow", 1'b0, 1'b0);
    @(posedge clk);
    #2 j = 1'b0; k = 1'b1;
    #1 lit("midhigh", 1'b0, 1'b0);
    @(negedge clk);
    #2 lit("edge_applies", 1'b1, 1'b1);

    // async reset in the middle of toggling
    step(1'b1, 1'b1); lit("pre_rst_a", 1'b0, 1'b0);
    step(1'b1, 1'b1); lit("pre_rst_b", 1'b1, 1'b1);
    #1 rst_n = 1'b0;
    #1 lit("async_rst", 1'b0, 1'b1);
    chk("async_rst_q4", q4, 4'b0110);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #2 lit("resume_tog", 1'b1, 1'b0);

    // reset asserted at the same instant as a falling edge
    @(posedge clk);
    #5 rst_n = 1'b0;
    #1 lit("rst_at_edge", 1'b0, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b1; j = 1'b0; k = 1'b0;
    @(negedge clk);
    #2 lit("post_rst_hold", 1'b0, 1'b1);

    // 4-bit mixed commands
    step4(4'b0101, 4'b1010); chk("w4_load", q4, 4'b1010);
    step4(4'b0101, 4'b0011); chk("w4_mixed", q4, 4'b1011);
    step4(4'b1111, 4'b1111); chk("w4_toggle", q4, 4'b0100);
    step4(4'b0000, 4'b0000); chk("w4_hold", q4, 4'b0100);

    clk_run = 1'b0;
    #10;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
